map_diff_scanner: RTL

MAP_DIFF_SCANNER -- requirements
Module: map_diff_scanner

---
 rtl/map_diff_scanner_if.sv | 28 ++
 rtl/map_diff_scanner.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/map_diff_scanner_if.sv
// Draw-command bus between the map diff scanner and a display driver.
// The scanner owns the cell coordinates and code; the driver acknowledges with cmd_done.
interface map_diff_scanner_if #(
    parameter int XW = 4,
    parameter int YW = 4
);
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [2:0]    obj_code;
    logic          draw_req;
    logic          cmd_done;

    modport master (
        output x,
        output y,
        output obj_code,
        output draw_req,
        input  cmd_done
    );

    modport slave (
        input  x,
        input  y,
        input  obj_code,
        input  draw_req,
        output cmd_done
    );
endinterface

// File: rtl/map_diff_scanner.sv
// Scans the game grid each frame, compares every cell against the previous frame
// and issues draw commands only for changed cells (or all cells on a full redraw).
module map_diff_scanner #(
    parameter int GRID_W = 16,
    parameter int GRID_H = 12,
    parameter int XW     = $clog2(GRID_W),
    parameter int YW     = $clog2(GRID_H)
) (
    input  logic clk,
    input  logic rst,
    input  logic en_update,
    input  logic snakeHead,
    input  logic snakeBody,
    input  logic apple,
    input  logic border,
    input  logic mode_pb,
    input  logic GameOver,
    map_diff_scanner_if.master dbus,
    output logic diff,
    output logic init_cycle,
    output logic full_mode,
    output logic busy,
    output logic frame_done,
    output logic sync_reset
);
    localparam int N  = GRID_W * GRID_H;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_CMD,
        S_NEXT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [2:0]    obj_q, obj_d;
    logic          diff_q, diff_d;
    logic          init_q, init_d;
    logic          full_q, full_d;
    logic          fmode_q, fmode_d;
    logic          sync_q, sync_d;
    logic          pb_q, go_q;
    logic [2:0]    store_q [N];

    logic [2:0]    cell_code;
    logic [2:0]    prev_code;
    logic [IW-1:0] idx;
    logic          store_we;
    logic          pb_rise, go_rise;

    assign pb_rise = mode_pb & ~pb_q;
    assign go_rise = GameOver & ~go_q;
    assign idx     = IW'(int'(y_q) * GRID_W + int'(x_q));
    assign prev_code = store_q[idx];

    always_comb begin
        cell_code = 3'b000;
        if (border)
            cell_code = 3'b100;
        else if (snakeHead)
            cell_code = 3'b001;
        else if (snakeBody)
            cell_code = 3'b010;
        else if (apple)
            cell_code = 3'b011;
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        obj_d    = obj_q;
        diff_d   = diff_q;
        init_d   = init_q;
        fmode_d  = fmode_q;
        sync_d   = 1'b0;
        store_we = 1'b0;
        full_d   = full_q ^ pb_rise;
        // GameOver aborts any frame, including one waiting on the driver.
        if (go_rise) begin
            state_d = S_IDLE;
            x_d     = '0;
            y_d     = '0;
            init_d  = 1'b1;
            sync_d  = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (en_update) begin
                        x_d     = '0;
                        y_d     = '0;
                        fmode_d = full_q;
                        state_d = S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    obj_d  = cell_code;
                    diff_d = (cell_code != prev_code);
                    if ((cell_code != prev_code) || init_q || fmode_q) begin
                        store_we = 1'b1;
                        state_d  = S_CMD;
                    end else begin
                        state_d = S_NEXT;
                    end
                end
                S_CMD: begin
                    if (dbus.cmd_done)
                        state_d = S_NEXT;
                end
                S_NEXT: begin
                    state_d = S_SAMPLE;
                    if (x_q == X_MAX) begin
                        if (y_q == Y_MAX) begin
                            state_d = S_DONE;
                        end else begin
                            x_d = '0;
                            y_d = y_q + 1'b1;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
                S_DONE: begin
                    init_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            obj_q   <= '0;
            diff_q  <= 1'b0;
            init_q  <= 1'b1;
            full_q  <= 1'b0;
            fmode_q <= 1'b0;
            sync_q  <= 1'b0;
            pb_q    <= 1'b0;
            go_q    <= 1'b0;
            for (int i = 0; i < N; i++)
                store_q[i] <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            obj_q   <= obj_d;
            diff_q  <= diff_d;
            init_q  <= init_d;
            full_q  <= full_d;
            fmode_q <= fmode_d;
            sync_q  <= sync_d;
            pb_q    <= mode_pb;
            go_q    <= GameOver;
            if (store_we)
                store_q[idx] <= cell_code;
        end
    end

    assign dbus.x        = x_q;
    assign dbus.y        = y_q;
    assign dbus.obj_code = obj_q;
    assign dbus.draw_req = (state_q == S_CMD);
    assign diff          = diff_q;
    assign init_cycle    = init_q;
    assign full_mode     = full_q;
    assign busy          = (state_q != S_IDLE);
    assign frame_done    = (state_q == S_DONE);
    assign sync_reset    = sync_q;
endmodule
